uart_echo_buffer: RTL and testbench

Parametrised echo/bridge engine between `uart_receiver` and `uart_transmitter`. It buffers received bytes in an internal FIFO of configurable depth and discards a configurable number of leading bytes per burst, where a burst ends after a programmable idle gap. In line mode it holds bytes until a terminator arrives. It replaces the hard-wired echo FSM and single-byte skip in the UART top level, and reports occupancy and overflow for debug and LCD logic.

---
 rtl/uart_echo_buffer.sv | 142 ++++++++++++++
 tb/tb_uart_echo_buffer.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_buffer.sv
// Echo/bridge engine between the UART receiver and transmitter: drops leading
// bytes of each burst, buffers the rest in a FIFO and hands them to the transmitter.
module uart_echo_buffer #(
    parameter int DATA_BITS   = 8,
    parameter int DEPTH       = 16,
    parameter int SKIP_COUNT  = 1,
    parameter int IDLE_CYCLES = 104166,
    parameter int LINE_MODE   = 0,
    parameter logic [DATA_BITS-1:0] TERMINATOR = DATA_BITS'('h0A)
) (
    input  logic                       clk_50MHz,
    input  logic                       reset,
    input  logic                       rx_valid,
    input  logic [DATA_BITS-1:0]       rx_data,
    input  logic                       tx_busy,
    input  logic                       tx_done_tick,
    input  logic                       clear_overflow,
    output logic                       tx_start,
    output logic [DATA_BITS-1:0]       tx_data,
    output logic                       fifo_full,
    output logic                       fifo_empty,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow,
    output logic                       burst_active
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int IW  = $clog2(IDLE_CYCLES);
    localparam int SKW = (SKIP_COUNT > 0) ? $clog2(SKIP_COUNT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_START, S_WAIT} state_t;

    state_t                 state, state_next;
    logic [DATA_BITS-1:0]   mem [DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count, count_next, release_cnt, eligible;
    logic [DATA_BITS-1:0]   rd_data;
    logic [IW-1:0]          idle_cnt;
    logic [SKW-1:0]         skip_left;
    logic                   skip_byte, store, wr_en, rd_en, term_wr;

    assign skip_byte  = rx_valid && (burst_active ? (skip_left != '0) : (SKIP_COUNT > 0));
    assign store      = rx_valid && !skip_byte;
    assign eligible   = (LINE_MODE != 0) ? release_cnt : count;
    assign rd_en      = (state == S_IDLE) && (eligible != '0) && !tx_busy;
    // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
    assign wr_en      = store && (!fifo_full || rd_en);
    assign count_next = count + CW'(wr_en) - CW'(rd_en);
    assign term_wr    = (LINE_MODE != 0) && wr_en && (rx_data == TERMINATOR);

    assign fifo_count = count;
    assign fifo_full  = (count == CW'(DEPTH));
    assign fifo_empty = (count == '0);

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            burst_active <= 1'b0;
            idle_cnt     <= '0;
            skip_left    <= '0;
        end else begin
            if (rx_valid) begin
                burst_active <= 1'b1;
                idle_cnt     <= '0;
            end else if (burst_active) begin
                idle_cnt <= idle_cnt + 1'b1;
                if (idle_cnt == IW'(IDLE_CYCLES - 2))
                    burst_active <= 1'b0;
            end
            if (rx_valid) begin
                if (!burst_active)
                    skip_left <= (SKIP_COUNT > 0) ? SKW'(SKIP_COUNT - 1) : '0;
                else if (skip_left != '0)
                    skip_left <= skip_left - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50MHz) begin
        if (wr_en)
            mem[wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            rd_data     <= '0;
            overflow    <= 1'b0;
            release_cnt <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            count <= count_next;
            if (store && !wr_en)
                overflow <= 1'b1;
            else if (clear_overflow)
                overflow <= 1'b0;
            // Forced flush when a full FIFO holds no complete line avoids deadlock.
            if (LINE_MODE != 0) begin
                if (term_wr)
                    release_cnt <= count_next;
                else if (fifo_full && release_cnt == '0)
                    release_cnt <= CW'(DEPTH);
                else if (rd_en)
                    release_cnt <= release_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            tx_data <= '0;
        end else begin
            state <= state_next;
            if (state == S_LOAD)
                tx_data <= rd_data;
        end
    end

    always_comb begin
        state_next = state;
        tx_start   = 1'b0;
        case (state)
            S_IDLE:  if (rd_en) state_next = S_LOAD;
            S_LOAD:  state_next = S_START;
            S_START: begin
                tx_start   = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT:  if (tx_done_tick) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Bench for uart_echo_buffer: one stream instance and one line-mode instance
// share the receive side; each has its own transmitter model and echo log.
module tb_uart_echo_buffer;

    localparam int DEPTH  = 4;
    localparam int IDLE   = 20;
    localparam int TX_LEN = 8;

    logic clk_50MHz = 1'b0;
    always #10 clk_50MHz = ~clk_50MHz;

    logic       reset, rx_valid, clear_overflow, hold_busy;
    logic [7:0] rx_data;

    logic       s_busy, s_done, s_start, s_full, s_empty, s_ovf, s_burst;
    logic [7:0] s_data;
    logic [2:0] s_count;
    logic       l_busy, l_done, l_start, l_full, l_empty, l_ovf, l_burst;
    logic [7:0] l_data;
    logic [2:0] l_count;

    int checks = 0;
    int failures = 0;
    int s_cnt = 0;
    int l_cnt = 0;
    logic [7:0] q_str[$];
    logic [7:0] q_line[$];

    uart_echo_buffer #(.DATA_BITS(8), .DEPTH(DEPTH), .SKIP_COUNT(1), .IDLE_CYCLES(IDLE),
                       .LINE_MODE(0), .TERMINATOR(8'h0A)) u_str (
        .clk_50MHz(clk_50MHz), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_busy(s_busy | hold_busy), .tx_done_tick(s_done), .clear_overflow(clear_overflow),
        .tx_start(s_start), .tx_data(s_data), .fifo_full(s_full), .fifo_empty(s_empty),
        .fifo_count(s_count), .overflow(s_ovf), .burst_active(s_burst));

    uart_echo_buffer #(.DATA_BITS(8), .DEPTH(DEPTH), .SKIP_COUNT(0), .IDLE_CYCLES(IDLE),
                       .LINE_MODE(1), .TERMINATOR(8'h0A)) u_line (
        .clk_50MHz(clk_50MHz), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_busy(l_busy | hold_busy), .tx_done_tick(l_done), .clear_overflow(clear_overflow),
        .tx_start(l_start), .tx_data(l_data), .fifo_full(l_full), .fifo_empty(l_empty),
        .fifo_count(l_count), .overflow(l_ovf), .burst_active(l_burst));

    // Transmitter models: busy for TX_LEN cycles after a start, then a done tick.
    always @(negedge clk_50MHz) begin
        if (reset) begin
            s_busy = 1'b0; s_done = 1'b0; s_cnt = 0;
        end else begin
            s_done = 1'b0;
            if (s_cnt > 0) begin
                s_cnt--;
                if (s_cnt == 0) begin s_busy = 1'b0; s_done = 1'b1; end
            end else if (s_start) begin
                q_str.push_back(s_data); s_busy = 1'b1; s_cnt = TX_LEN;
            end
        end
    end

    always @(negedge clk_50MHz) begin
        if (reset) begin
            l_busy = 1'b0; l_done = 1'b0; l_cnt = 0;
        end else begin
            l_done = 1'b0;
            if (l_cnt > 0) begin
                l_cnt--;
                if (l_cnt == 0) begin l_busy = 1'b0; l_done = 1'b1; end
            end else if (l_start) begin
                q_line.push_back(l_data); l_busy = 1'b1; l_cnt = TX_LEN;
            end
        end
    end

    task automatic gap(input int n);
        repeat (n) @(negedge clk_50MHz);
    endtask

    task automatic send(input logic [7:0] b, input logic clr);
        rx_data = b; rx_valid = 1'b1; clear_overflow = clr;
        @(negedge clk_50MHz);
        rx_valid = 1'b0; clear_overflow = 1'b0;
    endtask

    task automatic wait_echo(input int which, input int n, input int budget);
        int b;
        b = budget;
        while (((which == 0) ? q_str.size() : q_line.size()) < n && b > 0) begin
            @(negedge clk_50MHz);
            b--;
        end
    endtask

    task automatic do_reset();
        hold_busy = 1'b0; clear_overflow = 1'b0; rx_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk_50MHz);
        q_str.delete(); q_line.delete();
        reset = 1'b0;
        gap(2);
    endtask

    task automatic test_reset();
        logic [15:0] exp_v;
        exp_v = {1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        checks++;
        if ({s_start, s_data, s_count, s_empty, s_full, s_ovf, s_burst} !== exp_v) begin
            failures++;
            $display("FAIL reset_str_initial: got %h expected %h",
                     {s_start, s_data, s_count, s_empty, s_full, s_ovf, s_burst}, exp_v);
        end
        checks++;
        if ({l_start, l_data, l_count, l_empty, l_full, l_ovf, l_burst} !== exp_v) begin
            failures++;
            $display("FAIL reset_line_initial: got %h expected %h",
                     {l_start, l_data, l_count, l_empty, l_full, l_ovf, l_burst}, exp_v);
        end
        @(negedge clk_50MHz);
        reset = 1'b0;
        hold_busy = 1'b1;
        for (int i = 0; i < 6; i++) send(8'h30 + 8'(i), 1'b0);
        checks++;
        if (s_ovf !== 1'b1 || s_burst !== 1'b1) begin
            failures++;
            $display("FAIL reset_precond: got ovf=%b burst=%b expected 1 1", s_ovf, s_burst);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({s_start, s_data, s_count, s_empty, s_full, s_ovf, s_burst} !== exp_v) begin
            failures++;
            $display("FAIL reset_str_async: got %h expected %h",
                     {s_start, s_data, s_count, s_empty, s_full, s_ovf, s_burst}, exp_v);
        end
        checks++;
        if ({l_count, l_empty, l_full, l_ovf, l_burst} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_line_async: got %h expected %h",
                     {l_count, l_empty, l_full, l_ovf, l_burst}, {3'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        end
        do_reset();
    endtask

    task automatic test_stream_directed();
        logic [7:0] exp_q[$];
        do_reset();
        exp_q = '{8'h42, 8'h43, 8'h45};
        send(8'h41, 1'b0); gap(13);
        send(8'h42, 1'b0); gap(13);
        send(8'h43, 1'b0); gap(40);
        checks++;
        if (s_burst !== 1'b0) begin
            failures++;
            $display("FAIL stream_idle_burst: got %b expected 0", s_burst);
        end
        send(8'h44, 1'b0); gap(13);
        send(8'h45, 1'b0);
        wait_echo(0, 3, 300);
        gap(30);
        checks++;
        if (q_str.size() != 3) begin
            failures++;
            $display("FAIL stream_dir_len: got %0d expected 3", q_str.size());
        end
        for (int i = 0; i < 3 && i < q_str.size(); i++) begin
            checks++;
            if (q_str[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL stream_dir_byte%0d: got %h expected %h", i, q_str[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_latency();
        logic [7:0] b;
        do_reset();
        b = 8'($urandom);
        send(8'h11, 1'b0); gap(3);
        send(b, 1'b0);
        checks++;
        if (s_start !== 1'b0) begin failures++; $display("FAIL lat_c1: got %b expected 0", s_start); end
        gap(1);
        checks++;
        if (s_start !== 1'b0) begin failures++; $display("FAIL lat_c2: got %b expected 0", s_start); end
        gap(1);
        checks++;
        if (s_start !== 1'b1 || s_data !== b) begin
            failures++;
            $display("FAIL lat_c3: got start=%b data=%h expected 1 %h", s_start, s_data, b);
        end
        gap(1);
        checks++;
        if (s_start !== 1'b0) begin failures++; $display("FAIL lat_c4: got %b expected 0", s_start); end
        gap(IDLE - 5);
        checks++;
        if (s_burst !== 1'b1) begin failures++; $display("FAIL burst_hold: got %b expected 1", s_burst); end
        gap(1);
        checks++;
        if (s_burst !== 1'b0) begin failures++; $display("FAIL burst_fall: got %b expected 0", s_burst); end
    endtask

    task automatic test_stream_random();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int len;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            len = $urandom_range(1, 5);
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom);
                if (i >= 1) exp_q.push_back(b);
                send(b, 1'b0);
                gap($urandom_range(11, 16));
            end
            gap(30);
            checks++;
            if (s_burst !== 1'b0) begin
                failures++;
                $display("FAIL rand_burst_end%0d: got %b expected 0", k, s_burst);
            end
        end
        wait_echo(0, exp_q.size(), 600);
        gap(20);
        checks++;
        if (q_str.size() != exp_q.size()) begin
            failures++;
            $display("FAIL rand_len: got %0d expected %0d", q_str.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < q_str.size(); i++) begin
            checks++;
            if (q_str[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL rand_byte%0d: got %h expected %h", i, q_str[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] bs[6];
        do_reset();
        hold_busy = 1'b1;
        send(8'h10, 1'b0); gap(1);
        for (int i = 0; i < 6; i++) begin
            bs[i] = 8'($urandom);
            send(bs[i], (i == 5));
            gap(1);
        end
        checks++;
        if ({s_full, s_count, s_ovf, s_empty} !== {1'b1, 3'd4, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL ovf_state: got full=%b count=%0d ovf=%b empty=%b expected 1 4 1 0",
                     s_full, s_count, s_ovf, s_empty);
        end
        hold_busy = 1'b0;
        wait_echo(0, 4, 300);
        gap(30);
        checks++;
        if (q_str.size() != 4) begin
            failures++;
            $display("FAIL ovf_len: got %0d expected 4", q_str.size());
        end
        for (int i = 0; i < 4 && i < q_str.size(); i++) begin
            checks++;
            if (q_str[i] !== bs[i]) begin
                failures++;
                $display("FAIL ovf_byte%0d: got %h expected %h", i, q_str[i], bs[i]);
            end
        end
        checks++;
        if (s_ovf !== 1'b1 || s_empty !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky: got ovf=%b empty=%b expected 1 1", s_ovf, s_empty);
        end
        clear_overflow = 1'b1; gap(1); clear_overflow = 1'b0;
        checks++;
        if (s_ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b expected 0", s_ovf); end
    endtask

    task automatic test_line_directed();
        logic [7:0] exp_q[$];
        logic [7:0] bs[5];
        do_reset();
        exp_q = '{8'h41, 8'h42, 8'h0A};
        send(8'h41, 1'b0); gap(13);
        send(8'h42, 1'b0); gap(100);
        checks++;
        if (q_line.size() != 0 || l_count !== 3'd2) begin
            failures++;
            $display("FAIL line_hold: got echoes=%0d count=%0d expected 0 2", q_line.size(), l_count);
        end
        send(8'h0A, 1'b0);
        wait_echo(1, 3, 200);
        gap(20);
        checks++;
        if (q_line.size() != 3) begin
            failures++;
            $display("FAIL line_len: got %0d expected 3", q_line.size());
        end
        for (int i = 0; i < 3 && i < q_line.size(); i++) begin
            checks++;
            if (q_line[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL line_byte%0d: got %h expected %h", i, q_line[i], exp_q[i]);
            end
        end
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bs[i] = 8'($urandom);
            if (bs[i] == 8'h0A) bs[i] = 8'h0B;
            send(bs[i], 1'b0);
        end
        wait_echo(1, 4, 300);
        gap(30);
        checks++;
        if (q_line.size() != 4 || l_ovf !== 1'b1) begin
            failures++;
            $display("FAIL flush_state: got echoes=%0d ovf=%b expected 4 1", q_line.size(), l_ovf);
        end
        for (int i = 0; i < 4 && i < q_line.size(); i++) begin
            checks++;
            if (q_line[i] !== bs[i]) begin
                failures++;
                $display("FAIL flush_byte%0d: got %h expected %h", i, q_line[i], bs[i]);
            end
        end
    endtask

    task automatic test_line_random();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int len;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            len = $urandom_range(0, 2);
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom);
                if (b == 8'h0A) b = 8'h0B;
                exp_q.push_back(b);
                send(b, 1'b0); gap(2);
            end
            gap(40);
            checks++;
            if (q_line.size() != exp_q.size() - len) begin
                failures++;
                $display("FAIL lrand_hold%0d: got %0d expected %0d", k, q_line.size(), exp_q.size() - len);
            end
            exp_q.push_back(8'h0A);
            send(8'h0A, 1'b0);
            wait_echo(1, exp_q.size(), 300);
            gap(5);
        end
        gap(20);
        checks++;
        if (q_line.size() != exp_q.size()) begin
            failures++;
            $display("FAIL lrand_len: got %0d expected %0d", q_line.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < q_line.size(); i++) begin
            checks++;
            if (q_line[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL lrand_byte%0d: got %h expected %h", i, q_line[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        send(8'h20, 1'b0); gap(2);
        for (int i = 0; i < 4; i++) begin
            send(8'h60 + 8'(i), 1'b0);
            if (i < 3) gap(2);
        end
        checks++;
        if (s_count !== 3'd3 || q_str.size() != 1 || s_busy !== 1'b1) begin
            failures++;
            $display("FAIL midrst_precond: got count=%0d echoes=%0d busy=%b expected 3 1 1",
                     s_count, q_str.size(), s_busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({s_count, s_start, s_burst, s_empty} !== {3'd0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL midrst_state: got count=%0d start=%b burst=%b empty=%b expected 0 0 0 1",
                     s_count, s_start, s_burst, s_empty);
        end
        @(negedge clk_50MHz);
        q_str.delete(); q_line.delete();
        reset = 1'b0;
        gap(2);
        send(8'h55, 1'b0);
        gap(40);
        checks++;
        if (q_str.size() != 0 || s_count !== 3'd0) begin
            failures++;
            $display("FAIL midrst_skip: got echoes=%0d count=%0d expected 0 0", q_str.size(), s_count);
        end
    endtask

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        clear_overflow = 1'b0; hold_busy = 1'b0;
        #5;
        test_reset();
        test_stream_directed();
        test_latency();
        test_stream_random();
        test_overflow();
        test_line_directed();
        test_line_random();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
